// File: rtl/score_counter.sv
// rtl/score_counter.sv - serial BCD score accumulator with frame-stable display and extra-life pulse
module score_counter #(
  parameter int GOLD_H       = 2,
  parameter int DIAMOND_H    = 1,
  parameter int MONSTER_H    = 5,
  parameter int LIFE_EVERY_K = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       score_clear,
  input  logic       player_eat_gold,
  input  logic       player_eat_dimond,
  input  logic       monster_killed,
  output logic [3:0] digit_thousands,
  output logic [3:0] digit_hundreds,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_singles,
  output logic       extra_life,
  output logic       busy,
  output logic       pending_overflow
);

  localparam int LW = (LIFE_EVERY_K > 1) ? $clog2(LIFE_EVERY_K) : 1;

  typedef enum logic {IDLE = 1'b0, ADD = 1'b1} state_t;

  state_t        state;
  state_t        next_state;
  logic [7:0]    pending;
  logic [3:0]    work_th;
  logic [3:0]    work_hu;
  logic [LW-1:0] life_cnt;

  logic [9:0]    add_sum;
  logic [9:0]    pend_calc;
  logic          pend_sat;
  logic [7:0]    pend_next;
  logic          at_max;
  logic          incr;
  logic          carry;
  logic          life_wrap;

  // Scores are always whole hundreds, so the low digits are fixed at zero.
  assign digit_tens    = 4'd0;
  assign digit_singles = 4'd0;

  // Pending arithmetic: all events add at once, ADD drains one hundred per cycle, clamp at 255.
  always_comb begin
    add_sum   = (player_eat_gold   ? 10'(GOLD_H)    : 10'd0)
              + (player_eat_dimond ? 10'(DIAMOND_H) : 10'd0)
              + (monster_killed    ? 10'(MONSTER_H) : 10'd0);
    pend_calc = {2'b00, pending} + add_sum - {9'd0, (state == ADD)};
    pend_sat  = (pend_calc > 10'd255);
    pend_next = pend_sat ? 8'hFF : pend_calc[7:0];
    at_max    = (state == ADD) && (work_th == 4'd9) && (work_hu == 4'd9);
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: start draining once something is queued, stop when the queue empties or score is maxed.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (pending != 8'd0) next_state = ADD;
      ADD:  if (at_max || (pend_next == 8'd0)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (score_clear) next_state = IDLE;
  end

  // Outputs of the FSM: busy flag, increment enable, thousands carry and life wrap.
  always_comb begin
    busy      = (state == ADD);
    incr      = (state == ADD) && !at_max;
    carry     = incr && (work_hu == 4'd9);
    life_wrap = carry && (life_cnt == LW'(LIFE_EVERY_K - 1));
  end

  // Pending queue and sticky overflow flag; reaching the score ceiling throws queued points away.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending          <= 8'd0;
      pending_overflow <= 1'b0;
    end else if (score_clear) begin
      pending          <= 8'd0;
      pending_overflow <= 1'b0;
    end else if (at_max) begin
      pending <= 8'd0;
    end else begin
      pending <= pend_next;
      if (pend_sat) pending_overflow <= 1'b1;
    end
  end

  // Working BCD score, one hundred per ADD cycle with decimal carry into thousands.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      work_th <= 4'd0;
      work_hu <= 4'd0;
    end else if (score_clear) begin
      work_th <= 4'd0;
      work_hu <= 4'd0;
    end else if (incr) begin
      if (work_hu == 4'd9) begin
        work_hu <= 4'd0;
        work_th <= work_th + 4'd1;
      end else begin
        work_hu <= work_hu + 4'd1;
      end
    end
  end

  // Thousands-carry counter; extra_life fires on the same edge the counter wraps.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      life_cnt   <= '0;
      extra_life <= 1'b0;
    end else if (score_clear) begin
      life_cnt   <= '0;
      extra_life <= 1'b0;
    end else begin
      extra_life <= life_wrap;
      if (carry) life_cnt <= life_wrap ? '0 : life_cnt + LW'(1);
    end
  end

  // Display shadow: only updates at frame boundaries so the renderer never sees a mid-frame change.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digit_thousands <= 4'd0;
      digit_hundreds  <= 4'd0;
    end else if (score_clear) begin
      digit_thousands <= 4'd0;
      digit_hundreds  <= 4'd0;
    end else if (startOfFrame) begin
      digit_thousands <= work_th;
      digit_hundreds  <= work_hu;
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// tb/tb_score_counter.sv - self-checking bench for score_counter
module tb_score_counter;

  logic       clk;
  logic       resetN;
  logic       sof, clr, gold, dia, mon;
  logic [3:0] d_th, d_hu, d_te, d_si;
  logic       xlife, busy, ovf;

  int total = 0;
  int bad   = 0;
  int xl_seen = 0;

  score_counter dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (sof),
    .score_clear       (clr),
    .player_eat_gold   (gold),
    .player_eat_dimond (dia),
    .monster_killed    (mon),
    .digit_thousands   (d_th),
    .digit_hundreds    (d_hu),
    .digit_tens        (d_te),
    .digit_singles     (d_si),
    .extra_life        (xlife),
    .busy              (busy),
    .pending_overflow  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: score counted in plain hundreds (0..99), queue as an integer.
  typedef struct packed {
    logic [7:0] score;
    logic [7:0] pend;
    logic [7:0] disp;
    logic       busy;
    logic       ovf;
    logic       xl;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, logic g, logic d, logic k, logic sf, logic cl);
    mstate_t n;
    int adds;
    int np;
    int sc;
    n    = s;
    n.xl = 1'b0;
    adds = (g ? 2 : 0) + (d ? 1 : 0) + (k ? 5 : 0);
    if (cl) begin
      n = '0;
    end else begin
      if (sf) n.disp = s.score;
      if (s.busy) begin
        if (int'(s.score) == 99) begin
          n.pend = 8'd0;
          n.busy = 1'b0;
        end else begin
          sc      = int'(s.score) + 1;
          n.score = 8'(sc);
          n.xl    = (sc % 20 == 0);
          np      = int'(s.pend) + adds - 1;
          if (np > 255) begin
            np    = 255;
            n.ovf = 1'b1;
          end
          n.pend = 8'(np);
          n.busy = (np != 0);
        end
      end else begin
        np = int'(s.pend) + adds;
        if (np > 255) begin
          np    = 255;
          n.ovf = 1'b1;
        end
        n.pend = 8'(np);
        n.busy = (s.pend != 8'd0);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) m <= '0;
    else         m <= model_next(m, gold, dia, mon, sof, clr);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("thousands", int'(d_th), int'(m.disp) / 10);
    chk("hundreds",  int'(d_hu), int'(m.disp) % 10);
    chk("tens",      int'(d_te), 0);
    chk("singles",   int'(d_si), 0);
    chk("extra_life", int'(xlife), int'(m.xl));
    chk("busy",      int'(busy), int'(m.busy));
    chk("overflow",  int'(ovf), int'(m.ovf));
    chk("pending",   int'(dut.pending), int'(m.pend));
    if (xlife) xl_seen++;
  end

  task automatic cyc(input logic g, input logic d, input logic k, input logic sf, input logic cl);
    gold = g; dia = d; mon = k; sof = sf; clr = cl;
    @(negedge clk);
    gold = 1'b0; dia = 1'b0; mon = 1'b0; sof = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n, output int bc);
    bc = 0;
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (busy) bc++;
    end
  endtask

  task automatic show(input int th, input int hu, input string name);
    cyc(0, 0, 0, 1, 0);
    chk({name, "_th"}, int'(d_th), th);
    chk({name, "_hu"}, int'(d_hu), hu);
  endtask

  initial begin
    int bc;
    int x0;
    resetN = 1'b0;
    sof = 1'b0; clr = 1'b0; gold = 1'b0; dia = 1'b0; mon = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_th",   int'(d_th), 0);
    chk("rst_hu",   int'(d_hu), 0);
    chk("rst_xl",   int'(xlife), 0);
    chk("rst_ovf",  int'(ovf), 0);
    resetN = 1'b1;

    // single gold
    cyc(1, 0, 0, 0, 0);
    idle(10, bc);
    chk("gold_busy", bc, 2);
    show(0, 2, "gold");

    // three events at once
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 0);
    chk("trio_pend", int'(dut.pending), 8);
    idle(20, bc);
    chk("trio_busy", bc, 8);
    show(0, 8, "trio");

    // thousands carry and extra life
    cyc(0, 1, 0, 0, 0);
    idle(5, bc);
    x0 = xl_seen;
    cyc(0, 1, 0, 0, 0);
    idle(5, bc);
    show(1, 0, "k1");
    chk("k1_nolife", xl_seen - x0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(20, bc);
    show(1, 9, "s1900");
    x0 = xl_seen;
    cyc(0, 1, 0, 0, 0);
    idle(5, bc);
    chk("k2_life", xl_seen - x0, 1);
    show(2, 0, "k2");

    // climb to 9800 then saturate
    x0 = xl_seen;
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(100, bc);
    chk("climb_lives", xl_seen - x0, 3);
    show(9, 8, "s9800");
    cyc(1, 0, 0, 0, 0);
    idle(6, bc);
    chk("sat_busy", bc, 2);
    show(9, 9, "s9900");
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0);
      idle(4, bc);
      chk("sat_more_busy", bc, 1);
    end
    chk("sat_pend", int'(dut.pending), 0);
    show(9, 9, "s9900b");

    // queue overflow
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 45; i++) cyc(1, 1, 1, 0, 0);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_pend", int'(dut.pending), 255);
    cyc(0, 0, 0, 0, 1);
    chk("ovf_clr_flag", int'(ovf), 0);
    chk("ovf_clr_pend", int'(dut.pending), 0);

    // clear while busy with a simultaneous event
    cyc(1, 1, 1, 0, 0);
    idle(3, bc);
    show(0, 2, "pre_clr");
    cyc(1, 0, 0, 0, 1);
    chk("clr_pend", int'(dut.pending), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_th", int'(d_th), 0);
    chk("clr_hu", int'(d_hu), 0);
    idle(3, bc);
    chk("clr_quiet", bc, 0);

    // asynchronous reset in the middle of ADD
    cyc(0, 0, 1, 0, 0);
    idle(2, bc);
    show(0, 1, "pre_rst");
    chk("pre_rst_busy", int'(busy), 1);
    resetN = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_hu", int'(d_hu), 0);
    chk("arst_pend", int'(dut.pending), 0);
    @(negedge clk);
    resetN = 1'b1;
    idle(5, bc);
    chk("arst_quiet", bc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
